pwm_bank: RTL and testbench
===========================

Name: pwm_bank

Overview:
- Eight-channel PWM generator on the FPGA fabric, directly downstream of the HPS system.
- Its Avalon-MM slave is driven by the lightweight HPS-to-FPGA bridge; its select input is driven by the system's 8-bit pwm_select export.
- PWM outputs go to the GPIO header pin mux.
- All channels share one prescaler and period counter; each channel has its own duty register.
- Duty and period changes are double-buffered and take effect only at a period boundary, so no runt pulses are produced.

Parameters:
- NCH, 8: number of PWM channels (1..8).
- CW, 16: width of the period/duty counter.
- PSW, 16: width of the prescaler.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  4  word address.
- avs_chipselect  in  1  slave select.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, registered.
- pwm_select  in  NCH  per-channel pin-mux grant from the HPS system.
- pwm_out  out  NCH  PWM waveforms to the pin mux.
- period_tick  out  1  one-cycle pulse at each period wrap.

Behaviour:
- Register map (word addresses):
  - 0 CTRL: bit0 EN.
  - 1 PRESCALE (PSW bits).
  - 2 PERIOD (CW bits).
  - 3 STATUS: bit0 WRAP flag, write-1-to-clear.
  - 8..8+NCH-1 DUTY[i] (CW bits).
  - Unused addresses read 0 and ignore writes. Unused high bits read 0.
- Reads: avs_readdata updates the cycle after chipselect&read (fixed 1-cycle latency, no waitrequest). It holds its value otherwise.
- Writes: take effect the cycle after chipselect&write. Writes go to shadow registers PERIOD and DUTY; PRESCALE and CTRL are immediate.
- Prescaler: ps_cnt counts 0..PRESCALE. tick=1 when ps_cnt==PRESCALE, then ps_cnt returns to 0. PRESCALE=0 gives a tick every clock.
- Period counter: cnt advances by 1 on each tick. When cnt==per_act and tick, cnt wraps to 0, so the period is per_act+1 ticks.
- Wrap cycle actions:
  - per_act and duty_act[i] load from their shadows.
  - period_tick pulses for one cycle.
  - STATUS.WRAP sets.
  - If a W1C write coincides with a set, the set wins.
- Output: pwm_out[i] is registered = EN & pwm_select[i] & (cnt < duty_act[i]), so it lags cnt by 1 clock.
  - DUTY=0: constant low.
  - DUTY>PERIOD: constant high.
  - No glitch on pwm_select changes beyond the 1-cycle register delay.
- Disabled (EN=0):
  - ps_cnt and cnt are held at 0; pwm_out=0; period_tick=0.
  - per_act and duty_act track their shadows continuously, so an enable starts immediately with current values.
- EN 0->1: the first tick occurs PRESCALE+1 clocks after the write takes effect.
- Reset state:
  - All registers and shadows are 0; ps_cnt and cnt are 0.
  - pwm_out=0, period_tick=0, avs_readdata=0.
  - Reset mid-period aborts the period immediately (asynchronous).
- Width rule: all comparisons are unsigned CW-bit. Writedata is truncated to the register width.

Optional Feature:
- Macro: PWM_BANK_IRQ_EN.
- When defined:
  - Adds output irq (1 bit) = STATUS.WRAP & CTRL.bit1 (IRQEN). CTRL.bit1 becomes read/write.
  - irq is level, registered, and deasserts the cycle after the W1C write takes effect.
  - irq is intended for the system's ilc_irq input.
- When undefined:
  - No irq port.
  - CTRL.bit1 reads 0 and ignores writes.

Decomposition:
- Package pwm_bank_pkg holds:
  - Register address localparams (ADDR_CTRL=0, ADDR_PRESCALE=1, ADDR_PERIOD=2, ADDR_STATUS=3, ADDR_DUTY0=8).
  - CTRL bit index constants.
  - Reset-value constants.
- One sub-module, pwm_bank_timebase: prescaler, period counter, wrap/tick generation, and the per_act load strobe.
- The per-channel compare is a generate loop in the top level.

Test Plan:
- Basic waveform: PRESCALE=0, PERIOD=9, DUTY0=3, pwm_select=8'h01, EN=1 -> pwm_out[0] is high 3 clocks and low 7 clocks, repeating every 10 clocks; period_tick pulses every 10 clocks.
- Duty extremes: DUTY1=0 and DUTY2=20 with PERIOD=9 -> pwm_out[1] is constantly 0 and pwm_out[2] is constantly 1 (pwm_select=8'h06).
- Double buffering: mid-period write DUTY0=7 -> the current period keeps 3 high clocks; the next period after period_tick shows 7 high clocks.
- Prescaler: PRESCALE=4, PERIOD=3, DUTY0=2 -> period is 20 clocks, high time is 10 clocks.
- Gating and reset:
  - pwm_select[0] dropped -> pwm_out[0]=0 one clock later.
  - reset_n asserted mid-period -> all outputs 0 immediately; a CTRL read after release returns 0.
- STATUS/IRQ (with PWM_BANK_IRQ_EN): IRQEN=1 -> irq rises after the first wrap. Writing STATUS=1 clears irq; if the W1C write lands on a wrap cycle, irq stays high.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// pwm_bank shared constants: register map, CTRL bit positions, reset values.
// Optional IRQ output is enabled by defining PWM_BANK_IRQ_EN.
package pwm_bank_pkg;

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_PRESCALE = 4'd1;
    localparam logic [3:0] ADDR_PERIOD   = 4'd2;
    localparam logic [3:0] ADDR_STATUS   = 4'd3;
    localparam logic [3:0] ADDR_DUTY0    = 4'd8;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_IRQEN = 1;
    localparam int STATUS_WRAP = 0;

    localparam int RST_PRESCALE = 0;
    localparam int RST_PERIOD   = 0;
    localparam int RST_DUTY     = 0;

endpackage

// File: rtl/pwm_bank_timebase.sv
// Shared prescaler and period counter; flags the wrap cycle and the
// cycles in which the active period/duty registers should reload.
module pwm_bank_timebase #(
    parameter int CW  = 16,
    parameter int PSW = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic [PSW-1:0] prescale,
    input  logic [CW-1:0]  per_act,
    output logic [CW-1:0]  cnt,
    output logic           wrap,
    output logic           load
);

    logic [PSW-1:0] ps_cnt;
    logic           tick;

    assign tick = en && (ps_cnt == prescale);
    assign wrap = tick && (cnt == per_act);
    // Disabled: actives follow shadows so an enable starts on fresh values.
    assign load = wrap || !en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_cnt <= '0;
            cnt    <= '0;
        end else if (!en) begin
            ps_cnt <= '0;
            cnt    <= '0;
        end else begin
            ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
            if (tick) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Eight-channel double-buffered PWM bank with Avalon-MM register access.
// Define PWM_BANK_IRQ_EN to add the irq output and CTRL.IRQEN bit.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int NCH = 8,
    parameter int CW  = 16,
    parameter int PSW = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [3:0]     avs_address,
    input  logic           avs_chipselect,
    input  logic           avs_write,
    input  logic [31:0]    avs_writedata,
    input  logic           avs_read,
    output logic [31:0]    avs_readdata,
    input  logic [NCH-1:0] pwm_select,
    output logic [NCH-1:0] pwm_out,
`ifdef PWM_BANK_IRQ_EN
    output logic           irq,
`endif
    output logic           period_tick
);

    logic           en;
    logic [PSW-1:0] prescale;
    logic [CW-1:0]  per_sh;
    logic [CW-1:0]  per_act;
    logic [CW-1:0]  duty_sh  [NCH];
    logic [CW-1:0]  duty_act [NCH];
    logic           wrap_flag;
    logic [CW-1:0]  cnt;
    logic           wrap;
    logic           load;
    logic [NCH-1:0] cmp;
    logic [31:0]    rd_mux;
    logic           we;
    logic           re;
    logic           unused_wd;

`ifdef PWM_BANK_IRQ_EN
    logic irqen;
`endif

    assign we        = avs_chipselect && avs_write;
    assign re        = avs_chipselect && avs_read;
    assign unused_wd = ^avs_writedata;

    pwm_bank_timebase #(
        .CW  (CW),
        .PSW (PSW)
    ) u_timebase (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .prescale (prescale),
        .per_act  (per_act),
        .cnt      (cnt),
        .wrap     (wrap),
        .load     (load)
    );

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL: begin
                rd_mux[CTRL_EN] = en;
`ifdef PWM_BANK_IRQ_EN
                rd_mux[CTRL_IRQEN] = irqen;
`endif
            end
            ADDR_PRESCALE: rd_mux[PSW-1:0] = prescale;
            ADDR_PERIOD:   rd_mux[CW-1:0]  = per_sh;
            ADDR_STATUS:   rd_mux[STATUS_WRAP] = wrap_flag;
            default: ;
        endcase
        for (int i = 0; i < NCH; i++) begin
            if (avs_address == ADDR_DUTY0 + 4'(i)) begin
                rd_mux[CW-1:0] = duty_sh[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en           <= 1'b0;
            prescale     <= PSW'(RST_PRESCALE);
            per_sh       <= CW'(RST_PERIOD);
            per_act      <= CW'(RST_PERIOD);
            wrap_flag    <= 1'b0;
            period_tick  <= 1'b0;
            avs_readdata <= '0;
            for (int i = 0; i < NCH; i++) begin
                duty_sh[i]  <= CW'(RST_DUTY);
                duty_act[i] <= CW'(RST_DUTY);
            end
        end else begin
            if (we && avs_address == ADDR_CTRL) begin
                en <= avs_writedata[CTRL_EN];
            end
            if (we && avs_address == ADDR_PRESCALE) begin
                prescale <= avs_writedata[PSW-1:0];
            end
            if (we && avs_address == ADDR_PERIOD) begin
                per_sh <= avs_writedata[CW-1:0];
            end
            for (int i = 0; i < NCH; i++) begin
                if (we && avs_address == ADDR_DUTY0 + 4'(i)) begin
                    duty_sh[i] <= avs_writedata[CW-1:0];
                end
            end
            // A wrap in the same cycle as a W1C keeps the flag set.
            if (wrap) begin
                wrap_flag <= 1'b1;
            end else if (we && avs_address == ADDR_STATUS &&
                         avs_writedata[STATUS_WRAP]) begin
                wrap_flag <= 1'b0;
            end
            if (load) begin
                per_act <= per_sh;
                for (int i = 0; i < NCH; i++) begin
                    duty_act[i] <= duty_sh[i];
                end
            end
            period_tick <= wrap;
            if (re) begin
                avs_readdata <= rd_mux;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign cmp[g] = cnt < duty_act[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= en ? (pwm_select & cmp) : '0;
        end
    end

`ifdef PWM_BANK_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqen <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (we && avs_address == ADDR_CTRL) begin
                irqen <= avs_writedata[CTRL_IRQEN];
            end
            irq <= wrap_flag && irqen;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: register table, directed waveform
// sequences and a randomized run against a period-position model.
module tb_pwm_bank;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  avs_address = '0;
    logic        avs_chipselect = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [7:0]  pwm_select = '0;
    logic [7:0]  pwm_out;
    logic        period_tick;
`ifdef PWM_BANK_IRQ_EN
    logic        irq;
    localparam logic [31:0] CTRL_RB = 32'h2;
`else
    localparam logic [31:0] CTRL_RB = 32'h0;
`endif

    int checks = 0;
    int failures = 0;
    logic chk_on = 1'b0;
    int hi[8];
    int tk;

    pwm_bank dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs_address    (avs_address),
        .avs_chipselect (avs_chipselect),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .pwm_select     (pwm_select),
        .pwm_out        (pwm_out),
`ifdef PWM_BANK_IRQ_EN
        .irq            (irq),
`endif
        .period_tick    (period_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: position within the current period in clocks, plain arithmetic.
    logic        m_en, m_irqen, m_tick, m_flag, m_irq;
    int unsigned m_ps, m_per_sh, m_per_act;
    int unsigned m_duty_sh[8], m_duty_act[8];
    longint      m_pos;
    logic [7:0]  m_out;
    logic [31:0] m_rd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_en = 0; m_irqen = 0; m_tick = 0; m_flag = 0; m_irq = 0;
            m_ps = 0; m_per_sh = 0; m_per_act = 0; m_pos = 0;
            m_out = 0; m_rd = 0;
            for (int i = 0; i < 8; i++) begin
                m_duty_sh[i] = 0;
                m_duty_act[i] = 0;
            end
        end else begin
            longint len;
            int unsigned pcnt;
            logic w;
            int a;
            logic [31:0] rv;
            a = int'(avs_address);
            len = (longint'(m_per_act) + 1) * (longint'(m_ps) + 1);
            pcnt = int'(m_pos / (longint'(m_ps) + 1));
            w = m_en && (m_pos == len - 1);
            for (int i = 0; i < 8; i++)
                m_out[i] = m_en && pwm_select[i] && (pcnt < m_duty_act[i]);
            m_tick = w;
            m_irq = m_flag && m_irqen;
            if (avs_chipselect && avs_read) begin
                rv = 0;
                if (a == 0) rv = {30'b0, m_irqen, m_en};
                if (a == 1) rv = m_ps;
                if (a == 2) rv = m_per_sh;
                if (a == 3) rv = {31'b0, m_flag};
                if (a >= 8) rv = m_duty_sh[a-8];
                m_rd = rv;
            end
            if (!m_en || w) begin
                m_per_act = m_per_sh;
                for (int i = 0; i < 8; i++) m_duty_act[i] = m_duty_sh[i];
            end
            m_pos = (!m_en || w) ? 0 : m_pos + 1;
            if (w) m_flag = 1;
            else if (avs_chipselect && avs_write && a == 3 && avs_writedata[0])
                m_flag = 0;
            if (avs_chipselect && avs_write) begin
                if (a == 0) begin
                    m_en = avs_writedata[0];
`ifdef PWM_BANK_IRQ_EN
                    m_irqen = avs_writedata[1];
`endif
                end
                if (a == 1) m_ps = avs_writedata & 32'hFFFF;
                if (a == 2) m_per_sh = avs_writedata & 32'hFFFF;
                if (a >= 8) m_duty_sh[a-8] = avs_writedata & 32'hFFFF;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("pwm_out", 32'(pwm_out), 32'(m_out));
            check("period_tick", 32'(period_tick), 32'(m_tick));
            check("readdata", avs_readdata, m_rd);
`ifdef PWM_BANK_IRQ_EN
            check("irq", 32'(irq), 32'(m_irq));
`endif
        end
    end

    task automatic step();
        @(negedge clk);
        avs_chipselect = 0;
        avs_write = 0;
        avs_read = 0;
    endtask

    task automatic set_write(input int a, input logic [31:0] d);
        avs_chipselect = 1; avs_write = 1;
        avs_address = 4'(a); avs_writedata = d;
    endtask

    task automatic set_read(input int a);
        avs_chipselect = 1; avs_read = 1; avs_address = 4'(a);
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        set_write(a, d);
        step();
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        set_read(a);
        step();
        d = avs_readdata;
    endtask

    task automatic wait_tick(input int lim, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!period_tick && n < lim);
        check("wait_tick", 32'(period_tick), 32'd1);
    endtask

    task automatic count_run(input int n);
        tk = 0;
        for (int i = 0; i < 8; i++) hi[i] = 0;
        repeat (n) begin
            step();
            for (int i = 0; i < 8; i++) hi[i] += int'(pwm_out[i]);
            tk += int'(period_tick);
        end
    endtask

    typedef struct {
        int          addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } reg_vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reg_vec_t tv[8];
        logic [31:0] rd;
        int n;
        int r;

        tv[0] = '{0,  32'hFFFF_FFFE, CTRL_RB};
        tv[1] = '{1,  32'h1234_5678, 32'h0000_5678};
        tv[2] = '{2,  32'hABCD_EF01, 32'h0000_EF01};
        tv[3] = '{3,  32'hFFFF_FFFF, 32'h0};
        tv[4] = '{4,  32'hDEAD_BEEF, 32'h0};
        tv[5] = '{7,  32'hFFFF_FFFF, 32'h0};
        tv[6] = '{8,  32'hFFFF_1234, 32'h0000_1234};
        tv[7] = '{15, 32'h0001_ABCD, 32'h0000_ABCD};

        repeat (3) @(negedge clk);
        check("rst_pwm_out", 32'(pwm_out), 32'h0);
        check("rst_tick", 32'(period_tick), 32'h0);
        check("rst_readdata", avs_readdata, 32'h0);
        reset_n = 1;
        chk_on = 1;

        for (int i = 0; i < 8; i++) begin
            bus_write(tv[i].addr, tv[i].wd);
            bus_read(tv[i].addr, rd);
            check($sformatf("reg_rb_%0d", tv[i].addr), rd, tv[i].exp);
        end

        bus_write(0, 0);
        bus_write(1, 0);
        bus_write(2, 9);
        bus_write(8, 3);
        pwm_select = 8'h01;
        bus_write(0, 1);
        wait_tick(100, n);
        count_run(10);
        check("basic_hi", hi[0], 3);
        check("basic_tick", tk, 1);
        count_run(20);
        check("basic_hi2", hi[0], 6);
        check("basic_tick2", tk, 2);

        bus_write(9, 0);
        bus_write(10, 20);
        pwm_select = 8'h07;
        wait_tick(100, n);
        count_run(20);
        check("duty0_hi", hi[1], 0);
        check("duty_big_hi", hi[2], 20);
        check("duty_ch0_hi", hi[0], 6);

        wait_tick(100, n);
        set_write(8, 7);
        count_run(10);
        check("dbuf_cur_hi", hi[0], 3);
        check("dbuf_cur_tick", tk, 1);
        count_run(10);
        check("dbuf_next_hi", hi[0], 7);

        bus_write(0, 0);
        bus_write(1, 4);
        bus_write(2, 3);
        bus_write(8, 2);
        pwm_select = 8'h01;
        bus_write(0, 1);
        wait_tick(100, n);
        check("en_first_tick", n, 20);
        count_run(20);
        check("ps_hi", hi[0], 10);
        check("ps_tick", tk, 1);

        n = 0;
        while (!pwm_out[0] && n < 40) begin
            step();
            n++;
        end
        check("gate_pre", 32'(pwm_out[0]), 32'd1);
        pwm_select = 8'h00;
        step();
        check("gate_off", 32'(pwm_out[0]), 32'd0);
        pwm_select = 8'h01;

        bus_read(2, rd);
        check("period_rb", rd, 32'd3);
        repeat (3) step();
        #2 reset_n = 0;
        #1;
        check("arst_pwm", 32'(pwm_out), 32'h0);
        check("arst_tick", 32'(period_tick), 32'h0);
        check("arst_rd", avs_readdata, 32'h0);
        @(negedge clk);
        reset_n = 1;
        bus_read(0, rd);
        check("post_rst_ctrl", rd, 32'h0);
        bus_read(2, rd);
        check("post_rst_period", rd, 32'h0);

`ifdef PWM_BANK_IRQ_EN
        bus_write(2, 9);
        bus_write(8, 3);
        bus_write(0, 3);
        check("irq_idle", 32'(irq), 32'd0);
        wait_tick(100, n);
        step();
        check("irq_rise", 32'(irq), 32'd1);
        bus_write(3, 1);
        step();
        check("irq_clear", 32'(irq), 32'd0);
        wait_tick(100, n);
        repeat (9) step();
        set_write(3, 1);
        step();
        step();
        check("irq_w1c_on_wrap", 32'(irq), 32'd1);
        bus_write(0, 0);
`endif

        bus_write(0, 0);
        bus_write(1, $urandom_range(0, 3));
        bus_write(2, $urandom_range(0, 12));
        for (int i = 0; i < 8; i++) bus_write(8 + i, $urandom_range(0, 16));
        pwm_select = 8'($urandom);
        bus_write(0, 1);
        repeat (4000) begin
            r = $urandom_range(0, 99);
            if (r < 6) set_write(8 + $urandom_range(0, 7), $urandom_range(0, 16));
            else if (r < 8) set_write(2, $urandom_range(0, 12));
            else if (r < 10) set_write(3, $urandom);
            else if (r < 16) set_read($urandom_range(0, 15));
            else if (r < 18) pwm_select = 8'($urandom);
            else if (r < 19) begin
                if (m_en) set_write(0, {30'b0, 1'($urandom), 1'b0});
                else if ($urandom_range(0, 1) == 1) set_write(1, $urandom_range(0, 3));
                else set_write(0, {30'b0, 1'($urandom), 1'b1});
            end else if (r < 20) set_write($urandom_range(4, 7), $urandom);
            step();
        end
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
